// File: rtl/puf_response_engine.sv
// Arbiter-PUF response engine: sequences relax/race cycles on an external delay-race core
// and majority-votes repeated evaluations of each challenge into a response word.
module puf_response_engine #(
    parameter int unsigned CHAL_W        = 8,
    parameter int unsigned RESP_W        = 32,
    parameter int unsigned VOTES         = 5,
    parameter int unsigned RELAX_CYCLES  = 2,
    parameter int unsigned SETTLE_CYCLES = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic [CHAL_W-1:0]            seed,
    output logic                         busy,
    output logic                         done,
    output logic [RESP_W-1:0]            response,
    output logic [$clog2(RESP_W+1)-1:0]  unstable_count,
    output logic [CHAL_W-1:0]            race_challenge,
    output logic                         race_launch,
    input  logic                         race_result
);

    localparam int unsigned UW     = $clog2(RESP_W + 1);
    localparam int unsigned KW     = $clog2(RESP_W + 1);
    localparam int unsigned VW     = $clog2(VOTES + 1);
    localparam int unsigned PH_MAX = (RELAX_CYCLES > SETTLE_CYCLES) ? RELAX_CYCLES
                                                                    : SETTLE_CYCLES;
    localparam int unsigned PW     = $clog2(PH_MAX + 1);

    localparam logic [KW-1:0] K_LAST      = KW'(RESP_W - 1);
    localparam logic [VW-1:0] V_LAST      = VW'(VOTES - 1);
    localparam logic [VW-1:0] V_ALL       = VW'(VOTES);
    localparam logic [VW-1:0] V_HALF      = VW'(VOTES / 2);
    localparam logic [PW-1:0] RELAX_LAST  = PW'(RELAX_CYCLES - 1);
    localparam logic [PW-1:0] SETTLE_LAST = PW'(SETTLE_CYCLES - 1);

    if ((VOTES % 2) == 0) begin : g_bad_votes
        $error("puf_response_engine: VOTES must be odd");
    end
    if (SETTLE_CYCLES < 3) begin : g_bad_settle
        $error("puf_response_engine: SETTLE_CYCLES must be at least 3");
    end
    if (RELAX_CYCLES < 1) begin : g_bad_relax
        $error("puf_response_engine: RELAX_CYCLES must be at least 1");
    end

    typedef enum logic [1:0] {
        StIdle,
        StRelax,
        StRace,
        StDone
    } state_t;

    state_t        state;
    logic [KW-1:0] k;
    logic [VW-1:0] v;
    logic [VW-1:0] ones;
    logic [PW-1:0] phase;
    logic          sync1;
    logic          sync2;

    logic [VW-1:0]     ones_next;
    logic              vote_bit;
    logic              vote_unstable;
    logic [RESP_W-1:0] resp_next;

    always_comb begin
        ones_next     = ones + VW'(sync2);
        vote_bit      = (ones_next > V_HALF);
        vote_unstable = (ones_next != '0) && (ones_next != V_ALL);
        resp_next     = response;
        for (int i = 0; i < RESP_W; i++) begin
            if (k == KW'(i)) begin
                resp_next[i] = vote_bit;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= StIdle;
            k              <= '0;
            v              <= '0;
            ones           <= '0;
            phase          <= '0;
            sync1          <= 1'b0;
            sync2          <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            response       <= '0;
            unstable_count <= '0;
            race_challenge <= '0;
            race_launch    <= 1'b0;
        end else begin
            // race_result is asynchronous to clk
            sync1 <= race_result;
            sync2 <= sync1;
            unique case (state)
                StIdle: begin
                    if (start) begin
                        race_challenge <= seed;
                        k              <= '0;
                        v              <= '0;
                        ones           <= '0;
                        phase          <= '0;
                        response       <= '0;
                        unstable_count <= '0;
                        busy           <= 1'b1;
                        state          <= StRelax;
                    end
                end
                StRelax: begin
                    if (phase == RELAX_LAST) begin
                        phase       <= '0;
                        race_launch <= 1'b1;
                        state       <= StRace;
                    end else begin
                        phase <= phase + PW'(1);
                    end
                end
                StRace: begin
                    if (phase == SETTLE_LAST) begin
                        phase       <= '0;
                        race_launch <= 1'b0;
                        if (v == V_LAST) begin
                            response <= resp_next;
                            if (vote_unstable) begin
                                unstable_count <= unstable_count + UW'(1);
                            end
                            v    <= '0;
                            ones <= '0;
                            if (k == K_LAST) begin
                                busy  <= 1'b0;
                                state <= StDone;
                            end else begin
                                k              <= k + KW'(1);
                                race_challenge <= race_challenge + CHAL_W'(1);
                                state          <= StRelax;
                            end
                        end else begin
                            v     <= v + VW'(1);
                            ones  <= ones_next;
                            state <= StRelax;
                        end
                    end else begin
                        phase <= phase + PW'(1);
                    end
                end
                StDone: begin
                    // First DONE cycle is quiet, the second carries the pulse
                    if (!done) begin
                        done <= 1'b1;
                    end else begin
                        done  <= 1'b0;
                        state <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: doc/puf_response_engine.md
PUF_RESPONSE_ENGINE -- requirements
Module: puf_response_engine

Interface
REQ-001 The block SHALL have parameter CHAL_W, default 8, giving the challenge width applied to the race core.
REQ-002 The block SHALL have parameter RESP_W, default 32, giving the number of response bits per request.
REQ-003 The block SHALL have parameter VOTES, default 5, giving the evaluations per response bit; it must be odd and at least 1.
REQ-004 The block SHALL have parameter RELAX_CYCLES, default 2, giving the cycles with launch low before each race; it must be at least 1.
REQ-005 The block SHALL have parameter SETTLE_CYCLES, default 4, giving the cycles with launch high per race; it must be at least 3.
REQ-006 The block SHALL have input clk, width 1: the single clock.
REQ-007 The block SHALL have input reset, width 1: asynchronous, active-high reset.
REQ-008 The block SHALL have input start, width 1: request pulse, honoured only in IDLE.
REQ-009 The block SHALL have input seed, width CHAL_W: base challenge, captured when start is accepted.
REQ-010 The block SHALL have output busy, width 1: high while a request is in progress.
REQ-011 The block SHALL have output done, width 1: a one-cycle completion pulse.
REQ-012 The block SHALL have output response, width RESP_W: the voted response word.
REQ-013 The block SHALL have output unstable_count, width $clog2(RESP_W+1): the number of bits whose votes were not unanimous.
REQ-014 The block SHALL have output race_challenge, width CHAL_W: the challenge driven to the external delay-race core.
REQ-015 The block SHALL have output race_launch, width 1: the race launch edge driven to the core.
REQ-016 The block SHALL have input race_result, width 1: the arbiter output of the core, which is asynchronous to clk.

Function
REQ-017 The FSM SHALL have states IDLE, RELAX, RACE, DONE.
REQ-018 In IDLE with start=1, on that edge the block SHALL capture seed, set bit index k=0 and vote index v=0, clear response and unstable_count, set busy=1, and enter RELAX.
REQ-019 The block SHALL drive race_challenge = (seed + k) mod 2^CHAL_W continuously while busy, so wrap-around is modular.
REQ-020 In RELAX, race_launch SHALL be 0 for exactly RELAX_CYCLES cycles, after which the FSM enters RACE.
REQ-021 In RACE, race_launch SHALL be 1 for exactly SETTLE_CYCLES cycles.
REQ-022 race_result SHALL pass through a two-flop synchronizer, and the synchronized value SHALL be sampled on the last RACE cycle.
REQ-023 Each sample SHALL increment v and add to a ones counter.
REQ-024 If v < VOTES-1, the FSM SHALL return to RELAX.
REQ-025 When v = VOTES-1, response[k] SHALL be set to (ones > VOTES/2).
REQ-026 When v = VOTES-1, unstable_count SHALL increment if 0 < ones < VOTES.
REQ-027 When v = VOTES-1, v and ones SHALL be cleared and k SHALL be incremented.
REQ-028 After the vote of bit k = RESP_W-1, the FSM SHALL enter DONE.
REQ-029 In DONE, done SHALL be 1 for one cycle and busy SHALL be 0; the FSM then returns to IDLE.
REQ-030 done SHALL rise exactly 1 + RESP_W*VOTES*(RELAX_CYCLES+SETTLE_CYCLES) edges after the edge that accepted start.
REQ-031 start SHALL be ignored while busy=1 or in DONE, with no restart and no state change.
REQ-032 response and unstable_count SHALL hold their values after DONE until the next accepted start.
REQ-033 race_launch SHALL be 0 in IDLE and DONE.
REQ-034 race_challenge SHALL hold its last value in IDLE.
REQ-035 Counters SHALL saturate-free: k, v and ones are sized to never overflow for legal parameters.
REQ-036 Illegal parameters (VOTES even, SETTLE_CYCLES<3, RELAX_CYCLES<1) SHALL trigger a simulation-time error.

Reset
REQ-037 Asserting reset SHALL immediately force IDLE, busy=0, done=0, race_launch=0, race_challenge=0, response=0, unstable_count=0, synchronizer flops=0, and counters=0.
REQ-038 Reset asserted mid-operation SHALL abort the request with no done pulse.
REQ-039 The first start SHALL be accepted on the first edge after reset deasserts.

Verification
REQ-040 Bench parameters SHALL be RESP_W=4, VOTES=3, RELAX=2, SETTLE=4, and the race model SHALL be result = challenge[0] with 1-ns delay: seed 8'h00, start -> challenges 00,01,02,03, response 4'hA, unstable_count 0, done 73 edges after start.
REQ-041 Wrap-around: seed 8'hFE -> challenges FE,FF,00,01, response 4'hA, unstable_count 0.
REQ-042 Noisy bit: the model alternates 1,0,1 on challenge 01 across votes -> response[1]=1, unstable_count 1; an alternation 0,1,0 -> response[1]=0, unstable_count 1.
REQ-043 start pulsed while busy=1 at edge 20 -> ignored, done still at edge 73, seed unchanged.
REQ-044 reset asserted during RACE of bit 2 -> race_launch, busy, response fall to 0 with no clock edge, no done pulse, and a new start after release completes normally.
REQ-045 Checks over all runs: race_launch high-phase length is always 4 cycles, low-phase length is always 2 cycles, and done is never wider than one cycle.
